// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot iteration core.
// Default number format is 4.23 signed fixed point.
package mandel_pkg;

  localparam int FIX_WIDTH = 27;
  localparam int FIX_FRAC  = 23;

  typedef logic signed [FIX_WIDTH-1:0] fix_t;

  localparam fix_t FIX_TWO  = fix_t'(2 << FIX_FRAC);
  localparam fix_t FIX_FOUR = fix_t'(4 << FIX_FRAC);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/mandel_iter_core_fix_mul.sv
// Combinational signed fixed-point multiply.
// The full-width product is rescaled by FRAC and truncated back to WIDTH.
module fix_mul
  import mandel_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] full;

  // Arithmetic shift keeps the sign; the integer overflow bits are discarded.
  function automatic logic signed [WIDTH-1:0] trunc_frac(input logic signed [2*WIDTH-1:0] x);
    return WIDTH'(x >>> FRAC);
  endfunction

  assign full = a * b;
  assign p    = trunc_frac(full);

endmodule

// File: rtl/mandel_iter_core.sv
// Single-point Mandelbrot escape-time iterator: z <- z^2 + c, one step per clock,
// with valid/ready handshakes on both sides and a synchronous flush.
module mandel_iter_core
  import mandel_pkg::*;
#(
  parameter int WIDTH  = FIX_WIDTH,
  parameter int FRAC   = FIX_FRAC,
  parameter int ITER_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  input  logic [ITER_W-1:0]       max_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ITER_W-1:0]       result_iter,
  output logic                    busy
);

  localparam logic signed [WIDTH:0] TWO   = (WIDTH+1)'(64'sd2 <<< FRAC);
  localparam logic signed [WIDTH:0] NTWO  = -TWO;
  localparam logic signed [WIDTH:0] FOUR  = (WIDTH+1)'(64'sd4 <<< FRAC);

  state_t state, state_nx;

  logic signed [WIDTH-1:0] z_r, z_i, c_r, c_i;
  logic [ITER_W-1:0]       iter, max_q;

  logic signed [WIDTH-1:0] zr2, zi2, zri;
  logic signed [WIDTH:0]   zr_x, zi_x, mag;
  logic signed [WIDTH-1:0] zr_nx, zi_nx;
  logic                    escape, at_cap;

  fix_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (.a(z_r), .b(z_r), .p(zr2));
  fix_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (.a(z_i), .b(z_i), .p(zi2));
  fix_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (.a(z_r), .b(z_i), .p(zri));

  // Component guards catch |z|>2 before the squares can overflow, so mag is
  // only trusted when both components are within [-2,2].
  always_comb begin
    zr_x   = {z_r[WIDTH-1], z_r};
    zi_x   = {z_i[WIDTH-1], z_i};
    mag    = {zr2[WIDTH-1], zr2} + {zi2[WIDTH-1], zi2};
    escape = (zr_x > TWO) || (zr_x < NTWO) ||
             (zi_x > TWO) || (zi_x < NTWO) ||
             (mag > FOUR);
    at_cap = (iter == max_q);
    zr_nx  = zr2 - zi2 + c_r;
    zi_nx  = (zri <<< 1) + c_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)         state_nx = ITER;
        ITER:    if (escape || at_cap) state_nx = DONE;
        DONE:    if (out_ready)        state_nx = IDLE;
        default:                       state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: capture on accept, step while iterating, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_r         <= '0;
      z_i         <= '0;
      c_r         <= '0;
      c_i         <= '0;
      iter        <= '0;
      max_q       <= '0;
      result_iter <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_r   <= cr;
            c_i   <= ci;
            max_q <= max_iter;
            z_r   <= '0;
            z_i   <= '0;
            iter  <= '0;
          end
        end
        ITER: begin
          if (escape) begin
            result_iter <= iter;
          end else if (at_cap) begin
            result_iter <= max_q;
          end else begin
            z_r  <= zr_nx;
            z_i  <= zi_nx;
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_core.sv
// Directed bench for mandel_iter_core in 4.23 format with hand-computed escape counts.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mandel_iter_core;
  import mandel_pkg::*;

  localparam int LIMIT = 1100;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  fix_t        cr, ci;
  logic [31:0] max_iter;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result_iter;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mandel_iter_core #(.WIDTH(27), .FRAC(23), .ITER_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cr          (cr),
    .ci          (ci),
    .max_iter    (max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_iter (result_iter),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Offer one point, wait for the result, optionally stall the output, then drain it.
  task automatic run_point(input string tag, input fix_t pr, input fix_t pi,
                           input logic [31:0] pmax, input logic [31:0] exp_res,
                           input int exp_lat, input int hold);
    int cyc;
    int stable;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    cr       = pr;
    ci       = pi;
    max_iter = pmax;
    in_valid = 1'b1;
    cyc      = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cr       = 27'h5555555;
      ci       = 27'h2aaaaaa;
      max_iter = 32'd7;
      cyc++;
    end while (!out_valid && cyc < LIMIT);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_result"}, result_iter, exp_res);
    check({tag, "_latency"}, cyc, exp_lat);
    stable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid && !in_ready && busy && result_iter == exp_res) stable++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, stable, hold);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after"}, in_ready, 1);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic start_point(input fix_t pr, input logic [31:0] pmax);
    @(negedge clk);
    cr       = pr;
    ci       = '0;
    max_iter = pmax;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cr = '0; ci = '0; max_iter = 32'd1000;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result_iter, 0);
    rst = 1'b1;

    run_point("c0",     27'h0000000, 27'h0, 32'd1000, 32'd1000, 1002, 0);
    run_point("c1",     27'h0800000, 27'h0, 32'd1000, 32'd3,    5,    20);
    run_point("cm2",    27'h7000000, 27'h0, 32'd1000, 32'd1000, 1002, 0);
    run_point("c2_m0",  27'h1000000, 27'h0, 32'd0,    32'd0,    2,    0);
    run_point("c2",     27'h1000000, 27'h0, 32'd1000, 32'd2,    4,    0);
    run_point("ci1",    27'h0000000, 27'h0800000, 32'd1000, 32'd1000, 1002, 0);

    // flush and in_valid together while idle: the point must be dropped
    @(negedge clk);
    cr = '0; max_iter = 32'd1000; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_valid_busy", busy, 0);
    check("flush_vs_valid_ready", in_ready, 1);

    // flush mid-iteration
    start_point(27'h0000000, 32'd1000);
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 0);

    // async reset mid-iteration on the retry
    start_point(27'h0000000, 32'd1000);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    check("arst_result", result_iter, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("arst_stays_idle", seen, 0);

    run_point("post_c1", 27'h0800000, 27'h0, 32'd1000, 32'd3, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
